// File: rtl/div3_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div3_pkg : shared types and constants for the serial divide-by-3     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package div3_pkg;

  localparam int DIVISOR = 3;
  localparam int REM_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/div3_rem_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div3_rem_step : one MSB-first remainder step, (r, b) -> (r', qbit)   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module div3_rem_step
  import div3_pkg::*;
(
  input  logic [REM_W-1:0] i_rem,
  input  logic             i_bit,
  output logic [REM_W-1:0] o_rem,
  output logic             o_qbit
);

  // 2r+b is simply the concatenation {r, b}; r never reaches 3 so t <= 5
  logic [REM_W:0] w_t;

  assign w_t    = {i_rem, i_bit};
  assign o_qbit = (w_t >= (REM_W+1)'(DIVISOR));
  assign o_rem  = o_qbit ? REM_W'(w_t - (REM_W+1)'(DIVISOR)) : w_t[REM_W-1:0];

endmodule
`default_nettype wire

// File: rtl/div3_serial.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div3_serial : bit-serial divide-by-3 with valid/ready on both sides  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module div3_serial
  import div3_pkg::*;
#(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [W-1:0]     i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [W-1:0]     o_quot,
  output logic [REM_W-1:0] o_rem
);

  localparam int CNT_W = $clog2(W+1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [W-1:0]       r_opnd;
  logic [W-1:0]       r_quot;
  logic [REM_W-1:0]   r_rem;
  logic [REM_W-1:0]   w_rem_nxt;
  logic               w_qbit;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_accept;

  assign w_accept = (r_state == IDLE) && i_in_valid;

  div3_rem_step u_step (
    .i_rem  (r_rem),
    .i_bit  (r_opnd[W-1]),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Leave SHIFT on the step that takes the counter from 1 to 0
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_in_valid) w_state_nxt = SHIFT;
      SHIFT:   if (r_cnt == CNT_W'(1)) w_state_nxt = DONE;
      DONE:    if (i_out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opnd <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_opnd <= i_in_data;
      r_quot <= '0;
      r_rem  <= '0;
      r_cnt  <= CNT_W'(W);
    end else if (r_state == SHIFT) begin
      r_opnd <= {r_opnd[W-2:0], 1'b0};
      r_quot <= {r_quot[W-2:0], w_qbit};
      r_rem  <= w_rem_nxt;
      r_cnt  <= r_cnt - CNT_W'(1);
    end
  end

  assign o_in_ready  = (r_state == IDLE);
  assign o_out_valid = (r_state == DONE);
  assign o_quot      = r_quot;
  assign o_rem       = r_rem;

endmodule
`default_nettype wire

// File: tb/tb_div3_serial.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_div3_serial : directed self-checking bench for div3_serial        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_div3_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v4, rdy4, ov4, or4;
  logic [3:0] d4, q4;
  logic [1:0] r4;
  logic       v8, rdy8, ov8, or8;
  logic [7:0] d8, q8;
  logic [1:0] r8;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div3_serial #(.W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(v4), .o_in_ready(rdy4), .i_in_data(d4),
    .o_out_valid(ov4), .i_out_ready(or4), .o_quot(q4), .o_rem(r4)
  );

  div3_serial #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(v8), .o_in_ready(rdy8), .i_in_data(d8),
    .o_out_valid(ov8), .i_out_ready(or8), .o_quot(q8), .o_rem(r8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic acc4(input logic [3:0] v, output int acc);
    int b = 0;
    @(negedge clk);
    v4 = 1'b1;
    d4 = v;
    while (!rdy4 && b < 30) begin
      @(negedge clk);
      b++;
    end
    chk("acc4_ready", 32'(rdy4), 1);
    @(posedge clk);
    @(negedge clk);
    v4  = 1'b0;
    acc = cyc;
  endtask

  task automatic res4(output logic [3:0] q, output logic [1:0] r, output int n);
    n = 0;
    while (!ov4 && n < 30) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    q = q4;
    r = r4;
  endtask

  task automatic op4(input logic [3:0] v, input string tag, input int eq, input int er, input int en);
    int a, n;
    logic [3:0] q;
    logic [1:0] r;
    acc4(v, a);
    res4(q, r, n);
    chk({tag, "_quot"}, 32'(q), eq);
    chk({tag, "_rem"},  32'(r), er);
    chk({tag, "_lat"},  n, en);
  endtask

  task automatic op8(input logic [7:0] v, input string tag, input int eq, input int er);
    int b = 0;
    int n = 0;
    @(negedge clk);
    v8 = 1'b1;
    d8 = v;
    while (!rdy8 && b < 30) begin
      @(negedge clk);
      b++;
    end
    @(posedge clk);
    @(negedge clk);
    v8 = 1'b0;
    while (!ov8 && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk({tag, "_quot"}, 32'(q8), eq);
    chk({tag, "_rem"},  32'(r8), er);
    chk({tag, "_lat"},  n, 8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int a, prev, n;
    logic [3:0] q;
    logic [1:0] r;
    logic seen;

    rst_n = 1'b0;
    v4 = 1'b0; d4 = '0; or4 = 1'b1;
    v8 = 1'b0; d8 = '0; or8 = 1'b1;
    #12;
    chk("rst_ready4", 32'(rdy4), 1);
    chk("rst_valid4", 32'(ov4), 0);
    chk("rst_quot4",  32'(q4), 0);
    chk("rst_rem4",   32'(r4), 0);
    chk("rst_ready8", 32'(rdy8), 1);
    chk("rst_valid8", 32'(ov8), 0);
    @(negedge clk);
    rst_n = 1'b1;

    op4(4'd0,  "dir0",  0, 0, 4);
    op4(4'd7,  "dir7",  2, 1, 4);
    op4(4'd14, "dir14", 4, 2, 4);
    op4(4'd15, "dir15", 5, 0, 4);

    prev = 0;
    for (int i = 0; i < 16; i++) begin
      acc4(4'(i), a);
      res4(q, r, n);
      chk($sformatf("sweep%0d_quot", i), 32'(q), i / 3);
      chk($sformatf("sweep%0d_rem", i),  32'(r), i % 3);
      if (i > 0) chk($sformatf("sweep%0d_gap", i), a - prev, 6);
      prev = a;
    end

    // back-pressure on operand 11, with a competing operand offered meanwhile
    @(negedge clk);
    or4 = 1'b0;
    acc4(4'd11, a);
    res4(q, r, n);
    chk("bp_quot", 32'(q), 3);
    chk("bp_rem",  32'(r), 2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      v4 = 1'b1;
      d4 = 4'd6;
      chk($sformatf("bp_hold%0d_valid", k), 32'(ov4), 1);
      chk($sformatf("bp_hold%0d_quot", k),  32'(q4), 3);
      chk($sformatf("bp_hold%0d_rem", k),   32'(r4), 2);
      chk($sformatf("bp_hold%0d_ready", k), 32'(rdy4), 0);
    end
    v4  = 1'b0;
    or4 = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(ov4), 0);
    chk("bp_release_ready", 32'(rdy4), 1);

    // 9 offered while 13 is in flight
    acc4(4'd13, a);
    v4 = 1'b1;
    d4 = 4'd9;
    res4(q, r, n);
    chk("busy13_quot", 32'(q), 4);
    chk("busy13_rem",  32'(r), 1);
    chk("busy13_lat",  n, 4);
    chk("busy13_ready", 32'(rdy4), 0);
    prev = a;
    acc4(4'd9, a);
    chk("busy9_gap", a - prev, 6);
    res4(q, r, n);
    chk("busy9_quot", 32'(q), 3);
    chk("busy9_rem",  32'(r), 0);

    // reset during the second SHIFT cycle
    acc4(4'd6, a);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(rdy4), 1);
    chk("midrst_valid", 32'(ov4), 0);
    chk("midrst_quot",  32'(q4), 0);
    chk("midrst_rem",   32'(r4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen = seen | ov4;
    end
    chk("midrst_no_valid", 32'(seen), 0);
    op4(4'd5, "post_rst5", 1, 2, 4);

    op8(8'd255, "w8_255", 85, 0);
    op8(8'd254, "w8_254", 84, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
